dual_issue_scheduler: RTL

//  In-order dual-issue scheduler between the decode stage and the execute units.

---
 rtl/scheduler_pkg.sv | 68 ++++++
 rtl/reg_scoreboard.sv | 34 +++
 rtl/dual_issue_scheduler.sv | 66 ++++++
 3 files changed

// File: rtl/scheduler_pkg.sv
// Shared opcode encoding, latency constants and opcode classification helpers
// for the dual-issue scheduler.
package scheduler_pkg;
  localparam int NREG    = 16;
  localparam int RW      = $clog2(NREG);
  localparam int ALU_LAT = 1;
  localparam int LD_LAT  = 2;
  localparam int MUL_LAT = 3;
  localparam int MAX_LAT = (MUL_LAT > LD_LAT) ? ((MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT)
                                              : ((LD_LAT > ALU_LAT) ? LD_LAT : ALU_LAT);
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef logic [3:0]       opcode_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam opcode_t OP_NOP = 4'h0;
  localparam opcode_t OP_ADD = 4'h1;
  localparam opcode_t OP_SUB = 4'h2;
  localparam opcode_t OP_MUL = 4'h3;
  localparam opcode_t OP_LD  = 4'h4;
  localparam opcode_t OP_ST  = 4'h5;
  localparam opcode_t OP_MOV = 4'h6;
  localparam opcode_t OP_OR  = 4'h7;
  localparam opcode_t OP_AND = 4'h8;
  localparam opcode_t OP_NOT = 4'h9;
  localparam opcode_t OP_LSL = 4'hA;
  localparam opcode_t OP_LSR = 4'hB;
  localparam opcode_t OP_CMP = 4'hC;
  localparam opcode_t OP_UBR = 4'hD;
  localparam opcode_t OP_BEQ = 4'hE;
  localparam opcode_t OP_BGT = 4'hF;

  function automatic logic is_writer(opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_LD, OP_MOV,
      OP_OR, OP_AND, OP_NOT, OP_LSL, OP_LSR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(opcode_t op);
    return (op != OP_NOP) && (op != OP_UBR);
  endfunction

  function automatic logic uses_rs2(opcode_t op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_CMP, OP_OR,
      OP_AND, OP_LSL, OP_LSR, OP_ST: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(opcode_t op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  function automatic logic is_branch(opcode_t op);
    return (op == OP_BEQ) || (op == OP_BGT) || (op == OP_UBR);
  endfunction

  function automatic cnt_t lat_of(opcode_t op);
    case (op)
      OP_LD:   return cnt_t'(LD_LAT);
      OP_MUL:  return cnt_t'(MUL_LAT);
      default: return cnt_t'(ALU_LAT);
    endcase
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register countdown scoreboard: a register is readable once its counter
// reaches zero. A load from either issue slot overrides the decrement.
module reg_scoreboard
  import scheduler_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ld0_en,
  input  logic [RW-1:0]   ld0_rd,
  input  cnt_t            ld0_lat,
  input  logic            ld1_en,
  input  logic [RW-1:0]   ld1_rd,
  input  cnt_t            ld1_lat,
  output logic [NREG-1:0] ready
);
  cnt_t cnt [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (ld0_en && ld0_rd == RW'(r))      cnt[r] <= ld0_lat;
        else if (ld1_en && ld1_rd == RW'(r)) cnt[r] <= ld1_lat;
        else if (cnt[r] != '0)               cnt[r] <= cnt[r] - cnt_t'(1);
      end
    end
  end

  always_comb begin
    ready = '0;
    for (int r = 0; r < NREG; r++) ready[r] = (cnt[r] == '0);
  end
endmodule

// File: rtl/dual_issue_scheduler.sv
// In-order dual-issue decision logic: operand readiness, multiplier and
// LD/ST port arbitration, intra-pair hazards and branch flush suppression.
module dual_issue_scheduler
  import scheduler_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          i0_valid,
  input  logic [3:0]    i0_opcode,
  input  logic [RW-1:0] i0_rd,
  input  logic [RW-1:0] i0_rs1,
  input  logic [RW-1:0] i0_rs2,
  input  logic          i1_valid,
  input  logic [3:0]    i1_opcode,
  input  logic [RW-1:0] i1_rd,
  input  logic [RW-1:0] i1_rs1,
  input  logic [RW-1:0] i1_rs2,
  output logic          issue0,
  output logic          issue1,
  output logic          stall,
  output logic          mul_busy
);
  logic [NREG-1:0] ready;
  cnt_t            mul_cnt;
  logic            src0_ok, src1_ok, mul0, mul1, wr0, wr1, raw01, waw01;

  reg_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .ld0_en  (issue0 & wr0),
    .ld0_rd  (i0_rd),
    .ld0_lat (lat_of(i0_opcode)),
    .ld1_en  (issue1 & wr1),
    .ld1_rd  (i1_rd),
    .ld1_lat (lat_of(i1_opcode)),
    .ready   (ready)
  );

  always_comb begin
    mul0    = (i0_opcode == OP_MUL);
    mul1    = (i1_opcode == OP_MUL);
    wr0     = is_writer(i0_opcode);
    wr1     = is_writer(i1_opcode);
    src0_ok = (~uses_rs1(i0_opcode) | ready[i0_rs1]) & (~uses_rs2(i0_opcode) | ready[i0_rs2]);
    src1_ok = (~uses_rs1(i1_opcode) | ready[i1_rs1]) & (~uses_rs2(i1_opcode) | ready[i1_rs2]);
    // Slot 1 may not consume or overwrite the result slot 0 is producing this cycle.
    raw01   = wr0 & ((uses_rs1(i1_opcode) & (i1_rs1 == i0_rd)) |
                     (uses_rs2(i1_opcode) & (i1_rs2 == i0_rd)));
    waw01   = wr0 & wr1 & (i1_rd == i0_rd);

    issue0 = i0_valid & ~flush & ~reset & src0_ok & ~(mul0 & mul_busy);
    issue1 = issue0 & i1_valid & src1_ok & ~is_branch(i1_opcode) & ~is_branch(i0_opcode)
           & ~raw01 & ~waw01 & ~(mul1 & (mul0 | mul_busy))
           & ~(is_mem(i0_opcode) & is_mem(i1_opcode));
    stall  = (i0_valid & ~issue0) | (i1_valid & ~issue1);
  end

  assign mul_busy = (mul_cnt != '0);

  always_ff @(posedge clk) begin
    if (reset)                                 mul_cnt <= '0;
    else if ((issue0 & mul0) | (issue1 & mul1)) mul_cnt <= cnt_t'(MUL_LAT);
    else if (mul_busy)                         mul_cnt <= mul_cnt - cnt_t'(1);
  end
endmodule
